// File: rtl/cpu_bus_pkg.sv
// Address map, region decode and screen-entry format for the CPU data bus.
// Pure definitions: no state, no latency, no handshakes.
package cpu_bus_pkg;

   localparam logic [15:0] RAM_BASE     = 16'h0000;
   localparam logic [15:0] SCREEN_BASE  = 16'h4000;
   localparam int          SCREEN_WORDS = 8192;
   localparam logic [15:0] SCREEN_END   = SCREEN_BASE + 16'(SCREEN_WORDS);
   localparam logic [15:0] KBD_ADDR     = 16'h6000;

   typedef enum logic [1:0] {RAM, SCREEN, KBD, UNMAPPED} region_t;

   typedef struct packed {
      logic [12:0] addr;
      logic [15:0] data;
   } scr_entry_t;

   // RAM may be shallower than its 16K window; the excess decodes as unmapped.
   function automatic region_t decode(input logic [15:0] a, input logic [16:0] ram_limit);
      logic [15:0] ram_off;
      ram_off = a - RAM_BASE;
      if (a < SCREEN_BASE)
         return ({1'b0, ram_off} < ram_limit) ? RAM : UNMAPPED;
      else if (a < SCREEN_END)
         return SCREEN;
      else if (a == KBD_ADDR)
         return KBD;
      else
         return UNMAPPED;
   endfunction

endpackage

// File: rtl/cpu_bus_fifo.sv
// First-word-fall-through FIFO: head visible combinationally, zero when empty.
// Pushes while full and pops while empty are ignored; the caller gates them.
module cpu_bus_fifo #(
   parameter int WIDTH = 29,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = empty ? '0 : mem[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= push_data;
   end

endmodule

// File: rtl/cpu_data_bus.sv
// CPU data-side responder: RAM, screen shadow + display FIFO, keyboard register.
// Reads are combinational; a screen write stalls the CPU while the FIFO is full.
module cpu_data_bus
   import cpu_bus_pkg::*;
#(
   parameter int RAM_WORDS  = 16384,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_m_addr,
   input  logic [15:0] i_m,
   input  logic        i_m_we,
   output logic [15:0] o_m,
   output logic        o_stall,
   output logic        o_scr_valid,
   output logic [12:0] o_scr_addr,
   output logic [15:0] o_scr_data,
   input  logic        i_scr_ready,
   input  logic        i_kbd_valid,
   input  logic [15:0] i_kbd_code,
   output logic        o_kbd_ready,
   output logic        o_err
);
   localparam int          RAW       = $clog2(RAM_WORDS);
   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [16:0] RAM_LIMIT = RAM_WORDS[16:0];

   logic [15:0] ram    [RAM_WORDS];
   logic [15:0] shadow [SCREEN_WORDS];
   logic [15:0] kbd_reg;
   region_t     region;
   scr_entry_t  head;
   scr_entry_t  entry;
   logic        full;
   logic        empty;
   logic [CW-1:0] count;
   logic        scr_wr;
   logic        push;
   logic        pop;

   assign region  = decode(i_m_addr, RAM_LIMIT);
   assign scr_wr  = i_m_we && (region == SCREEN);
   // Stall is judged on the registered count, so a same-cycle pop cannot rescue it.
   assign o_stall = scr_wr && full;
   assign push    = scr_wr && !full;
   assign pop     = !empty && i_scr_ready;

   assign entry.addr = i_m_addr[12:0];
   assign entry.data = i_m;

   cpu_bus_fifo #(
      .WIDTH ($bits(scr_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .push      (push),
      .push_data (entry),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   assign o_scr_valid = (count != '0);
   assign o_scr_addr  = head.addr;
   assign o_scr_data  = head.data;

   always_comb begin
      o_m = '0;
      unique case (region)
         RAM:      o_m = ram[i_m_addr[RAW-1:0]];
         SCREEN:   o_m = shadow[i_m_addr[12:0]];
         KBD:      o_m = kbd_reg;
         default:  o_m = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_m_we && region == RAM) ram[i_m_addr[RAW-1:0]] <= i_m;
      if (push) shadow[i_m_addr[12:0]] <= i_m;
   end

   // A key arriving on the same edge as the CPU's acknowledge must not be lost.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         kbd_reg     <= '0;
         o_err       <= 1'b0;
         o_kbd_ready <= 1'b0;
      end else begin
         o_kbd_ready <= 1'b1;
         if (i_kbd_valid)
            kbd_reg <= i_kbd_code;
         else if (i_m_we && region == KBD)
            kbd_reg <= '0;
         if (i_m_we && region == UNMAPPED)
            o_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_data_bus.sv
// Directed bench for cpu_data_bus: a vector table plus hand sequences for FIFO full and reset.
module tb_cpu_data_bus;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [15:0] i_m_addr = '0;
   logic [15:0] i_m = '0;
   logic        i_m_we = 1'b0;
   logic [15:0] o_m;
   logic        o_stall;
   logic        o_scr_valid;
   logic [12:0] o_scr_addr;
   logic [15:0] o_scr_data;
   logic        i_scr_ready = 1'b0;
   logic        i_kbd_valid = 1'b0;
   logic [15:0] i_kbd_code = '0;
   logic        o_kbd_ready;
   logic        o_err;

   int checks = 0;
   int failures = 0;

   cpu_data_bus dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_m_addr    (i_m_addr),
      .i_m         (i_m),
      .i_m_we      (i_m_we),
      .o_m         (o_m),
      .o_stall     (o_stall),
      .o_scr_valid (o_scr_valid),
      .o_scr_addr  (o_scr_addr),
      .o_scr_data  (o_scr_data),
      .i_scr_ready (i_scr_ready),
      .i_kbd_valid (i_kbd_valid),
      .i_kbd_code  (i_kbd_code),
      .o_kbd_ready (o_kbd_ready),
      .o_err       (o_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] wd;
      logic        we;
      logic        kv;
      logic [15:0] kc;
      logic        rdy;
      logic        chk_m;
      logic [15:0] m;
      logic        stall;
      logic        sv;
      logic [12:0] sa;
      logic [15:0] sd;
      logic        err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [15:0] addr, input logic [15:0] wd, input logic we,
                               input logic kv, input logic [15:0] kc, input logic rdy,
                               input logic chk_m, input logic [15:0] m, input logic stall,
                               input logic sv, input logic [12:0] sa, input logic [15:0] sd,
                               input logic err);
      vec_t v;
      v.addr = addr; v.wd = wd; v.we = we; v.kv = kv; v.kc = kc; v.rdy = rdy;
      v.chk_m = chk_m; v.m = m; v.stall = stall; v.sv = sv; v.sa = sa; v.sd = sd; v.err = err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
   task automatic drive(input logic [15:0] a, input logic [15:0] wd, input logic we,
                        input logic kv, input logic [15:0] kc, input logic rdy);
      @(negedge i_clk);
      i_m_addr = a; i_m = wd; i_m_we = we;
      i_kbd_valid = kv; i_kbd_code = kc; i_scr_ready = rdy;
      #1;
   endtask

   task automatic chk_head(input string nm, input logic sv, input logic [12:0] sa, input logic [15:0] sd);
      chk({nm, "_valid"}, 32'(o_scr_valid), 32'(sv));
      chk({nm, "_addr"},  32'(o_scr_addr),  32'(sa));
      chk({nm, "_data"},  32'(o_scr_data),  32'(sd));
   endtask

   logic [12:0] q_addr [8];
   logic [15:0] q_data [8];

   initial begin
      // addr wd we kv kc rdy | chk_m m stall sv sa sd err
      tbl.push_back(mk(16'h0010, 16'h1111, 1, 0, 16'h0, 0,  0, 16'h0000, 0, 0, 13'h0, 16'h0, 0));
      tbl.push_back(mk(16'h0010, 16'h1234, 1, 0, 16'h0, 0,  1, 16'h1111, 0, 0, 13'h0, 16'h0, 0));
      tbl.push_back(mk(16'h0010, 16'h0000, 0, 0, 16'h0, 0,  1, 16'h1234, 0, 0, 13'h0, 16'h0, 0));
      tbl.push_back(mk(16'h4005, 16'hFFFF, 1, 0, 16'h0, 1,  0, 16'h0000, 0, 0, 13'h0, 16'h0, 0));
      tbl.push_back(mk(16'h4005, 16'h0000, 0, 0, 16'h0, 1,  1, 16'hFFFF, 0, 1, 13'h5, 16'hFFFF, 0));
      tbl.push_back(mk(16'h4005, 16'h0000, 0, 0, 16'h0, 0,  1, 16'hFFFF, 0, 0, 13'h0, 16'h0, 0));
      tbl.push_back(mk(16'h6000, 16'h0000, 0, 1, 16'h0041, 0, 1, 16'h0000, 0, 0, 13'h0, 16'h0, 0));
      tbl.push_back(mk(16'h6000, 16'h0000, 0, 0, 16'h0, 0,  1, 16'h0041, 0, 0, 13'h0, 16'h0, 0));
      tbl.push_back(mk(16'h6000, 16'h9999, 1, 0, 16'h0, 0,  1, 16'h0041, 0, 0, 13'h0, 16'h0, 0));
      tbl.push_back(mk(16'h6000, 16'h0000, 0, 0, 16'h0, 0,  1, 16'h0000, 0, 0, 13'h0, 16'h0, 0));
      tbl.push_back(mk(16'h6000, 16'h9999, 1, 1, 16'h0042, 0, 1, 16'h0000, 0, 0, 13'h0, 16'h0, 0));
      tbl.push_back(mk(16'h6000, 16'h0000, 0, 0, 16'h0, 0,  1, 16'h0042, 0, 0, 13'h0, 16'h0, 0));
      tbl.push_back(mk(16'h7000, 16'hABCD, 1, 0, 16'h0, 0,  1, 16'h0000, 0, 0, 13'h0, 16'h0, 0));
      tbl.push_back(mk(16'h7000, 16'h0000, 0, 0, 16'h0, 0,  1, 16'h0000, 0, 0, 13'h0, 16'h0, 1));
      tbl.push_back(mk(16'h0010, 16'h0000, 0, 0, 16'h0, 0,  1, 16'h1234, 0, 0, 13'h0, 16'h0, 1));
      tbl.push_back(mk(16'h3FFF, 16'h5A5A, 1, 0, 16'h0, 0,  0, 16'h0000, 0, 0, 13'h0, 16'h0, 1));
      tbl.push_back(mk(16'h3FFF, 16'h0000, 0, 0, 16'h0, 0,  1, 16'h5A5A, 0, 0, 13'h0, 16'h0, 1));
      tbl.push_back(mk(16'h6001, 16'h0000, 0, 0, 16'h0, 0,  1, 16'h0000, 0, 0, 13'h0, 16'h0, 1));

      // Reset state while i_rst is held
      #2;
      chk_head("rst", 0, 13'h0, 16'h0);
      chk("rst_err", 32'(o_err), 32'h0);
      chk("rst_kbd_ready", 32'(o_kbd_ready), 32'h0);
      i_m_addr = 16'h6000; #1;
      chk("rst_kbd_read", 32'(o_m), 32'h0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk); #1;
      chk("kbd_ready_after_release", 32'(o_kbd_ready), 32'h1);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].addr, tbl[i].wd, tbl[i].we, tbl[i].kv, tbl[i].kc, tbl[i].rdy);
         if (tbl[i].chk_m) chk($sformatf("v%0d_m", i), 32'(o_m), 32'(tbl[i].m));
         chk($sformatf("v%0d_stall", i), 32'(o_stall), 32'(tbl[i].stall));
         chk_head($sformatf("v%0d_head", i), tbl[i].sv, tbl[i].sa, tbl[i].sd);
         chk($sformatf("v%0d_err", i), 32'(o_err), 32'(tbl[i].err));
      end

      // Known shadow value at 0x4100, drained immediately
      drive(16'h4100, 16'h7777, 1, 0, 16'h0, 1);
      chk("pre_stall", 32'(o_stall), 32'h0);
      drive(16'h4100, 16'h0000, 0, 0, 16'h0, 1);
      chk("pre_read", 32'(o_m), 32'h7777);
      chk_head("pre_head", 1, 13'h100, 16'h7777);
      drive(16'h4100, 16'h0000, 0, 0, 16'h0, 0);
      chk("pre_empty", 32'(o_scr_valid), 32'h0);

      // Fill the FIFO with ready low; last entry exercises the top screen word
      for (int i = 0; i < 8; i++) begin
         q_addr[i] = (i == 7) ? 13'h1FFF : 13'(16 + i);
         q_data[i] = 16'(16'h0100 + i);
         drive(16'h4000 + 16'(q_addr[i]), q_data[i], 1, 0, 16'h0, 0);
         chk($sformatf("fill%0d_stall", i), 32'(o_stall), 32'h0);
      end

      drive(16'h4100, 16'hBEEF, 1, 0, 16'h0, 0);
      chk("full_stall", 32'(o_stall), 32'h1);
      chk("full_shadow_old", 32'(o_m), 32'h7777);
      chk_head("full_head", 1, q_addr[0], q_data[0]);
      drive(16'h4100, 16'hBEEF, 1, 0, 16'h0, 1);
      chk("full_pop_still_stall", 32'(o_stall), 32'h1);
      drive(16'h4100, 16'hBEEF, 1, 0, 16'h0, 0);
      chk("retry_stall", 32'(o_stall), 32'h0);
      chk("retry_shadow_old", 32'(o_m), 32'h7777);
      chk_head("retry_head", 1, q_addr[1], q_data[1]);

      drive(16'h4100, 16'h0000, 0, 0, 16'h0, 0);
      chk("retry_shadow_new", 32'(o_m), 32'hBEEF);
      for (int i = 1; i < 8; i++) begin
         drive(16'h5FFF, 16'h0000, 0, 0, 16'h0, 1);
         chk_head($sformatf("drain%0d", i), 1, q_addr[i], q_data[i]);
      end
      chk("top_word_read", 32'(o_m), 32'h0107);
      drive(16'h4100, 16'h0000, 0, 0, 16'h0, 1);
      chk_head("drain_last", 1, 13'h100, 16'hBEEF);
      drive(16'h4100, 16'h0000, 0, 0, 16'h0, 0);
      chk_head("drained", 0, 13'h0, 16'h0);

      // Reset with entries queued
      drive(16'h0020, 16'hCAFE, 1, 0, 16'h0, 0);
      for (int i = 0; i < 3; i++) drive(16'h4200 + 16'(i), 16'(16'hA000 + i), 1, 0, 16'h0, 0);
      drive(16'h0020, 16'h0000, 0, 0, 16'h0, 0);
      chk("prerst_valid", 32'(o_scr_valid), 32'h1);
      chk("prerst_err", 32'(o_err), 32'h1);
      chk("prerst_kbd_ready", 32'(o_kbd_ready), 32'h1);
      i_rst = 1'b1; #1;
      chk_head("midrst", 0, 13'h0, 16'h0);
      chk("midrst_err", 32'(o_err), 32'h0);
      chk("midrst_kbd_ready", 32'(o_kbd_ready), 32'h0);
      chk("midrst_ram", 32'(o_m), 32'hCAFE);
      i_m_addr = 16'h6000; #1;
      chk("midrst_kbd", 32'(o_m), 32'h0);
      i_m_addr = 16'h4201; #1;
      chk("midrst_shadow", 32'(o_m), 32'hA001);
      @(negedge i_clk);
      i_rst = 1'b0;
      drive(16'h0020, 16'h0000, 0, 0, 16'h0, 0);
      chk("postrst_kbd_ready", 32'(o_kbd_ready), 32'h1);
      chk("postrst_valid", 32'(o_scr_valid), 32'h0);
      chk("postrst_ram", 32'(o_m), 32'hCAFE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
